muldiv_seq: RTL and testbench
=============================

# muldiv_seq

Iterative multiply/divide sequencer owning the HI/LO register pair of the pipelined CPU. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO issued from the EXE stage and runs a 32-step shift-add multiply or restoring divide over 33 busy cycles. It raises a stall request so the hazard logic holds IF/ID/EXE while a dependent HI/LO access or a second mul/div waits, and it supports flush abort from branch/exception control.

## Interface
- No parameters; data width fixed at 32.
- clk  in  1  single system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  valid mul/div/mt operation presented this cycle.
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 no-op.
- opnd_a  in  32  rs value (dividend / multiplicand / MT source).
- opnd_b  in  32  rt value (divisor / multiplier).
- rd_req  in  1  MFHI/MFLO in EXE needs hi/lo this cycle.
- flush  in  1  abort any in-flight operation.
- hi  out  32  HI register.
- lo  out  32  LO register.
- busy  out  1  high in states MUL, DIV, FIX.
- stall_req  out  1  combinational: busy & (start | rd_req).
- done  out  1  one-cycle pulse when hi/lo updated by a mul/div.
- div_by_zero  out  1  pulse coincident with done for DIV/DIVU with opnd_b = 0.

## Operation
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE: start & op in {MULT,MULTU} -> MUL; {DIV,DIVU} -> DIV. At the accepting edge latch operand magnitudes (signed ops: two's-complement absolute value; INT_MIN stays 0x80000000 as unsigned), result sign flags (quotient/product sign = a[31]^b[31], remainder sign = a[31]) and clear the 6-bit step counter.
- MTHI/MTLO in IDLE: hi (resp. lo) <= opnd_a at that edge; state stays IDLE; no busy, no done.
- MUL: each cycle, 64-bit accumulator {hi_acc, lo_acc} adds multiplicand if multiplier LSB set, shifts right 1; counter++.
- DIV: each cycle, restoring step: shift {rem, quo} left 1, subtract divisor from rem if no borrow and set quo LSB; counter++.
- Counter reaching 31 on a step edge -> FIX next. FIX: apply sign correction (negate 64-bit product; negate quotient/remainder per flags), write hi/lo -> DONE. DONE: done = 1 one cycle -> IDLE.
- Divide by zero: skip iteration arithmetic effects; FIX writes lo = 0xFFFFFFFF, hi = opnd_a as latched (raw); div_by_zero = 1 in DONE.
- start while busy: ignored (not latched); stall_req holds the issuing instruction until accepted. start in DONE is accepted as in IDLE.
- flush (priority over start, any state): next state IDLE; hi/lo unchanged; no done. flush with start in IDLE: start dropped, MTHI/MTLO not performed.
- rst low: state IDLE, hi = lo = 0, busy = done = div_by_zero = 0, counter = 0; overrides flush and start.
- INT_MIN / -1 (DIV): lo = 0x80000000, hi = 0; no trap.

## Timing
- start accepted at edge E0 -> busy high cycles E0+1 .. E0+33 (32 step cycles + FIX) -> hi/lo valid and done high in cycle after edge E0+33 -> IDLE after E0+34. Back-to-back: next start accepted at the DONE edge, E0+34.
- hi/lo never change during MUL/DIV; partial results live in internal registers; hi/lo update only at the FIX->DONE edge or MT edge.
- stall_req purely combinational from busy, start, rd_req; low in IDLE and DONE.
- MT write visible on hi/lo the cycle after the accepting edge.

## Test plan
- MULTU 0xFFFFFFFF x 0xFFFFFFFF at edge 0 -> busy cycles 1-33, done in cycle 34, hi = 0xFFFFFFFE, lo = 0x00000001.
- MULT -3 x 5 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFF1; DIV -7 / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
- DIVU 100 / 0 -> done & div_by_zero same cycle, lo = 0xFFFFFFFF, hi = 100.
- MTHI 0x1234 then MULTU 6x7, rd_req held during busy -> stall_req high 33 cycles, hi = 0, lo = 42 after done; second start during busy not latched.
- MTLO 0xAAAA, start DIVU, flush at busy cycle 10 -> IDLE next cycle, no done, lo stays 0xAAAA; flush+start same cycle -> nothing accepted.
- rst low at busy cycle 20 -> next cycle busy = 0, hi = lo = 0, no done; new op after release completes normally.

Source files
------------

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide unit owning the HI/LO pair: 32-step shift-add multiply or
// restoring divide, MTHI/MTLO writes, stall request for dependent accesses, flush abort.
module muldiv_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] opnd_a,
   input  logic [31:0] opnd_b,
   input  logic        rd_req,
   input  logic        flush,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy,
   output logic        stall_req,
   output logic        done,
   output logic        div_by_zero
);

   localparam int unsigned W  = 32;
   localparam int unsigned CW = 6;

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   typedef enum logic [2:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_FIX,
      S_DONE
   } state_e;

   state_e          state_q;
   logic [CW-1:0]   cnt_q;
   logic [W-1:0]    a_mag_q;
   logic [W-1:0]    b_mag_q;
   logic [W-1:0]    a_raw_q;
   logic [W-1:0]    acc_hi_q;
   logic [W-1:0]    acc_lo_q;
   logic            neg_q;
   logic            rem_neg_q;
   logic            is_div_q;
   logic            dbz_q;
   logic [W-1:0]    hi_q;
   logic [W-1:0]    lo_q;
   logic            busy_q;
   logic            done_q;
   logic            dbz_out_q;

   logic            signed_op_c;
   logic            is_mul_op_c;
   logic            is_div_op_c;
   logic [W-1:0]    a_mag_c;
   logic [W-1:0]    b_mag_c;
   logic [W:0]      mul_sum_c;
   logic [W:0]      div_sh_c;
   logic            div_ge_c;
   logic [W-1:0]    div_rem_c;
   logic [2*W-1:0]  prod_fix_c;
   logic [W-1:0]    quo_fix_c;
   logic [W-1:0]    rem_fix_c;

   // Operand decode and magnitude extraction; INT_MIN maps onto itself as an unsigned magnitude.
   assign signed_op_c = (op == OP_MULT) || (op == OP_DIV);
   assign is_mul_op_c = (op == OP_MULT) || (op == OP_MULTU);
   assign is_div_op_c = (op == OP_DIV)  || (op == OP_DIVU);
   assign a_mag_c     = (signed_op_c && opnd_a[W-1]) ? W'(~opnd_a + W'(1)) : opnd_a;
   assign b_mag_c     = (signed_op_c && opnd_b[W-1]) ? W'(~opnd_b + W'(1)) : opnd_b;

   // One shift-add multiply step: {acc_hi, acc_lo} holds partial product and remaining multiplier.
   assign mul_sum_c = acc_lo_q[0] ? ({1'b0, acc_hi_q} + {1'b0, a_mag_q}) : {1'b0, acc_hi_q};

   // One restoring divide step: acc_hi is the remainder, acc_lo shifts dividend out / quotient in.
   assign div_sh_c  = {acc_hi_q, acc_lo_q[W-1]};
   assign div_ge_c  = div_sh_c >= {1'b0, b_mag_q};
   assign div_rem_c = div_ge_c ? W'(div_sh_c - {1'b0, b_mag_q}) : div_sh_c[W-1:0];

   assign prod_fix_c = neg_q     ? (2*W)'(~{acc_hi_q, acc_lo_q} + (2*W)'(1)) : {acc_hi_q, acc_lo_q};
   assign quo_fix_c  = neg_q     ? W'(~acc_lo_q + W'(1)) : acc_lo_q;
   assign rem_fix_c  = rem_neg_q ? W'(~acc_hi_q + W'(1)) : acc_hi_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         a_mag_q   <= '0;
         b_mag_q   <= '0;
         a_raw_q   <= '0;
         acc_hi_q  <= '0;
         acc_lo_q  <= '0;
         neg_q     <= 1'b0;
         rem_neg_q <= 1'b0;
         is_div_q  <= 1'b0;
         dbz_q     <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         dbz_out_q <= 1'b0;
      end else begin
         done_q    <= 1'b0;
         dbz_out_q <= 1'b0;
         if (flush) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
         end else begin
            unique case (state_q)
               S_IDLE, S_DONE: begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  if (start && (is_mul_op_c || is_div_op_c)) begin
                     state_q   <= is_div_op_c ? S_DIV : S_MUL;
                     busy_q    <= 1'b1;
                     cnt_q     <= '0;
                     a_mag_q   <= a_mag_c;
                     b_mag_q   <= b_mag_c;
                     a_raw_q   <= opnd_a;
                     is_div_q  <= is_div_op_c;
                     dbz_q     <= (opnd_b == '0);
                     neg_q     <= signed_op_c && (opnd_a[W-1] ^ opnd_b[W-1]);
                     rem_neg_q <= signed_op_c && opnd_a[W-1];
                     acc_hi_q  <= '0;
                     acc_lo_q  <= is_div_op_c ? a_mag_c : b_mag_c;
                  end else if (start && (op == OP_MTHI)) begin
                     hi_q <= opnd_a;
                  end else if (start && (op == OP_MTLO)) begin
                     lo_q <= opnd_a;
                  end
               end
               S_MUL: begin
                  acc_hi_q <= mul_sum_c[W:1];
                  acc_lo_q <= {mul_sum_c[0], acc_lo_q[W-1:1]};
                  cnt_q    <= cnt_q + CW'(1);
                  if (cnt_q == CW'(31)) state_q <= S_FIX;
               end
               S_DIV: begin
                  if (!dbz_q) begin
                     acc_hi_q <= div_rem_c;
                     acc_lo_q <= {acc_lo_q[W-2:0], div_ge_c};
                  end
                  cnt_q <= cnt_q + CW'(1);
                  if (cnt_q == CW'(31)) state_q <= S_FIX;
               end
               S_FIX: begin
                  state_q   <= S_DONE;
                  busy_q    <= 1'b0;
                  done_q    <= 1'b1;
                  dbz_out_q <= is_div_q && dbz_q;
                  if (!is_div_q) begin
                     hi_q <= prod_fix_c[2*W-1:W];
                     lo_q <= prod_fix_c[W-1:0];
                  end else if (dbz_q) begin
                     hi_q <= a_raw_q;
                     lo_q <= '1;
                  end else begin
                     hi_q <= rem_fix_c;
                     lo_q <= quo_fix_c;
                  end
               end
               default: begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign hi          = hi_q;
   assign lo          = lo_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign div_by_zero = dbz_out_q;
   assign stall_req   = busy_q & (start | rd_req);

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed and random checks of muldiv_seq against a plain-arithmetic HI/LO model.
module tb_muldiv_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  op;
   logic [31:0] opnd_a;
   logic [31:0] opnd_b;
   logic        rd_req;
   logic        flush;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        stall_req;
   logic        done;
   logic        div_by_zero;

   int vectors     = 0;
   int miscompares = 0;

   muldiv_seq dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .op          (op),
      .opnd_a      (opnd_a),
      .opnd_b      (opnd_b),
      .rd_req      (rd_req),
      .flush       (flush),
      .hi          (hi),
      .lo          (lo),
      .busy        (busy),
      .stall_req   (stall_req),
      .done        (done),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference result {hi, lo} from ordinary integer arithmetic.
   function automatic logic [63:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (o)
         3'b000: begin p = 64'(sa * sb); return p; end
         3'b001: begin p = {32'b0, a} * {32'b0, b}; return p; end
         3'b010: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
         end
         3'b011: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
         default: return 64'd0;
      endcase
   endfunction

   // Issue a mul/div at the current negedge and check timing and results.
   task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b);
      logic [63:0] exp;
      logic [31:0] h0, l0;
      int n;
      bit moved;
      exp = ref_model(o, a, b);
      h0 = hi;
      l0 = lo;
      start = 1'b1; op = o; opnd_a = a; opnd_b = b;
      @(negedge clk);
      start = 1'b0; op = 3'b111;
      chk({tag, "_done_low_at_issue"}, 64'(done), 64'd0);
      n = 0;
      moved = 1'b0;
      while (busy && n < 40) begin
         if (hi !== h0 || lo !== l0 || done !== 1'b0) moved = 1'b1;
         n++;
         @(negedge clk);
      end
      chk({tag, "_busy_cycles"}, 64'(n), 64'd33);
      chk({tag, "_hilo_stable"}, 64'(moved), 64'd0);
      chk({tag, "_done"}, 64'(done), 64'd1);
      chk({tag, "_dbz"}, 64'(div_by_zero), 64'((o[1] == 1'b1) && (b == 32'd0)));
      chk({tag, "_hilo"}, {hi, lo}, exp);
   endtask

   initial begin
      logic [2:0]  ro;
      logic [31:0] ra, rb;
      int n, dones;

      rst = 1'b0; start = 1'b0; op = 3'b111; opnd_a = '0; opnd_b = '0;
      rd_req = 1'b0; flush = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_hilo", {hi, lo}, 64'd0);
      chk("reset_flags", {60'd0, busy, done, div_by_zero, stall_req}, 64'd0);
      rst = 1'b1;
      @(negedge clk);

      // Boundary directed cases; consecutive calls also exercise acceptance in DONE.
      run_op("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      chk("multu_max_exact", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
      run_op("mult_neg", 3'b000, 32'hFFFF_FFFD, 32'd5);
      chk("mult_neg_exact", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
      run_op("div_neg", 3'b010, 32'hFFFF_FFF9, 32'd2);
      chk("div_neg_exact", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
      run_op("div_intmin", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
      chk("div_intmin_exact", {hi, lo}, 64'h0000_0000_8000_0000);
      run_op("divu_zero", 3'b011, 32'd100, 32'd0);
      chk("divu_zero_exact", {hi, lo}, 64'h0000_0064_FFFF_FFFF);
      run_op("div_zero_neg", 3'b010, 32'hFFFF_FF00, 32'd0);
      @(negedge clk);
      chk("done_one_cycle", {62'd0, done, div_by_zero}, 64'd0);

      // MTHI/MTLO, then stall behaviour with rd_req held and a second start while busy.
      start = 1'b1; op = 3'b100; opnd_a = 32'h1234;
      chk("stall_low_idle", 64'(stall_req), 64'd0);
      @(negedge clk);
      start = 1'b0;
      chk("mthi", {hi, 31'd0, busy}, {32'h1234, 32'd0});
      start = 1'b1; op = 3'b001; opnd_a = 32'd6; opnd_b = 32'd7;
      @(negedge clk);
      start = 1'b0; rd_req = 1'b1;
      n = 0;
      dones = 0;
      for (int c = 1; c <= 40; c++) begin
         if (stall_req) n++;
         if (c == 5) begin start = 1'b1; op = 3'b001; opnd_a = 32'd3; opnd_b = 32'd3; end
         if (c == 6) start = 1'b0;
         @(negedge clk);
         if (done) dones++;
      end
      rd_req = 1'b0;
      chk("stall_cycles", 64'(n), 64'd33);
      chk("stall_done_count", 64'(dones), 64'd1);
      chk("stall_result", {hi, lo}, 64'd42);

      // Flush mid-divide, then flush coinciding with start.
      start = 1'b1; op = 3'b101; opnd_a = 32'hAAAA;
      @(negedge clk);
      start = 1'b1; op = 3'b011; opnd_a = 32'd1000; opnd_b = 32'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      chk("flush_busy_before", 64'(busy), 64'd1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_busy_after", 64'(busy), 64'd0);
      dones = 0;
      repeat (40) begin
         if (done || busy) dones++;
         @(negedge clk);
      end
      chk("flush_no_done", 64'(dones), 64'd0);
      chk("flush_lo_kept", 64'(lo), 64'h0000_AAAA);
      start = 1'b1; flush = 1'b1; op = 3'b101; opnd_a = 32'h5555;
      @(negedge clk);
      op = 3'b001;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      @(negedge clk);
      chk("flush_start_dropped", {lo, 31'd0, busy}, {32'h0000_AAAA, 32'd0});

      // Reset in the middle of a multiply.
      start = 1'b1; op = 3'b000; opnd_a = 32'd12345; opnd_b = 32'hFFFF_0000;
      @(negedge clk);
      start = 1'b0;
      repeat (19) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_mid_hilo", {hi, lo}, 64'd0);
      chk("rst_mid_flags", {61'd0, busy, done, div_by_zero}, 64'd0);
      rst = 1'b1;
      @(negedge clk);
      run_op("after_rst", 3'b000, 32'd12345, 32'hFFFF_0000);

      // Random operations, with small and zero divisors mixed in.
      for (int i = 0; i < 30; i++) begin
         ro = 3'($urandom_range(0, 3));
         ra = $urandom;
         rb = $urandom;
         if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 9));
         if ($urandom_range(0, 3) == 0) ra = ~32'($urandom_range(0, 9));
         run_op("rand", ro, ra, rb);
         if ($urandom_range(0, 1) == 0) @(negedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
